switch_mode_select: RTL

//  Multi-channel successor to the single-button toggle: per-channel release-edge detector and

---
 rtl/switch_mode_select.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/switch_mode_select.sv
// switch_mode_select: per-channel button release detector and
// wrap-around mode counter, with optional long-press reset.
//
// Optional feature macro: LONG_PRESS_EN
//   defined   : per-channel hold counter; a release after holding
//               for LONG_CYC cycles returns the mode to 0 and
//               pulses long_pulse instead of step_pulse.
//   undefined : no hold counters, long_pulse tied low, every
//               release is a short release.
//
// Parameters:
//   NUM_CH     number of independent button channels (>=1)
//   NUM_MODES  modes per channel (>=2), counted 0..NUM_MODES-1
//   LONG_CYC   hold length in clkin cycles that counts as long
//   MODE_W     width of one channel's mode field (derived)
//
// Ports:
//   clkin       system clock, rising edge
//   rst         synchronous reset, active-high
//   en          event enable; low = releases ignored
//   btn_in      debounced button levels, 1 = pressed
//   mode_out    channel c mode at [c*MODE_W +: MODE_W]
//   sel_out     LSB of each channel's mode
//   step_pulse  1-cycle pulse when a channel's mode advances
//   long_pulse  1-cycle pulse on long-press release
module switch_mode_select #(
   parameter int NUM_CH = 4,
   parameter int NUM_MODES = 2,
   parameter int LONG_CYC = 50_000_000,
   localparam int MODE_W = $clog2(NUM_MODES)
) (
   input  logic                     clkin,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_CH-1:0]        btn_in,
   output logic [NUM_CH*MODE_W-1:0] mode_out,
   output logic [NUM_CH-1:0]        sel_out,
   output logic [NUM_CH-1:0]        step_pulse,
   output logic [NUM_CH-1:0]        long_pulse
);

   localparam logic [MODE_W-1:0] MODE_LAST =
      MODE_W'(NUM_MODES - 1);

   if (NUM_CH < 1 || NUM_MODES < 2 || LONG_CYC < 1)
   begin : g_bad_cfg
      $error("switch_mode_select: bad parameters");
   end

   logic [NUM_CH-1:0]        prev_q, prev_d;
   logic [NUM_CH*MODE_W-1:0] mode_q, mode_d;
   logic [NUM_CH-1:0]        step_q, step_d;
   logic [NUM_CH-1:0]        rel;

   // A release is the registered level high and the live level
   // low; en only gates the event, never the history.
   assign rel = prev_q & ~btn_in & {NUM_CH{en}};

`ifdef LONG_PRESS_EN
   localparam int CNT_W = $clog2(LONG_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_CYC);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] long_q, long_d;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         // Counts cycles with both previous and current level
         // high; any low sample clears it.
         if (!btn_in[c]) begin
            cnt_d[c] = '0;
         end else if (prev_q[c] && cnt_q[c] != CNT_MAX) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
         end else begin
            cnt_d[c] = cnt_q[c];
         end
      end
   end
`endif

   always_comb begin
      prev_d = btn_in;
      mode_d = mode_q;
      step_d = '0;
`ifdef LONG_PRESS_EN
      long_d = '0;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef LONG_PRESS_EN
         if (rel[c] && cnt_q[c] == CNT_MAX) begin
            mode_d[c*MODE_W +: MODE_W] = '0;
            long_d[c] = 1'b1;
         end else
`endif
         if (rel[c]) begin
            step_d[c] = 1'b1;
            if (mode_q[c*MODE_W +: MODE_W] == MODE_LAST) begin
               mode_d[c*MODE_W +: MODE_W] = '0;
            end else begin
               mode_d[c*MODE_W +: MODE_W] =
                  mode_q[c*MODE_W +: MODE_W] + MODE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         prev_q <= '0;
         mode_q <= '0;
         step_q <= '0;
      end else begin
         prev_q <= prev_d;
         mode_q <= mode_d;
         step_q <= step_d;
      end
   end

`ifdef LONG_PRESS_EN
   always_ff @(posedge clkin) begin
      if (rst) begin
         long_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         long_q <= long_d;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   assign long_pulse = long_q;
`else
   assign long_pulse = '0;
`endif

   always_comb begin
      sel_out = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sel_out[c] = mode_q[c*MODE_W];
      end
   end

   assign mode_out   = mode_q;
   assign step_pulse = step_q;

endmodule
